jtag_scan_master: RTL and testbench

Synchronous JTAG scan master: the initiator end of the 4-bit-IR TAP interface. It converts IR-scan and DR-scan commands into cycle-exact TMS/TDI sequences and captures TDO into a response word. It shares CLK with the TAP, which acts as TCK, so the TAP's state advances on every CLK edge. Both blocks use the same RESET.

---
 rtl/jtag_scan_master.sv | 200 ++++++++++++++++++++
 tb/tb_jtag_scan_master.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_scan_master.sv
// jtag_scan_master
//   Initiator side of a 4-bit-IR JTAG TAP that shares CLK as TCK. It turns
//   IR/DR scan commands into cycle-exact TMS/TDI streams and gathers TDO into
//   a response word.
//
// Ports
//   CLK, RESET            clock (also TCK) and synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; ready only while idle
//   cmd_ir                1 = IR scan, 0 = DR scan
//   cmd_len               bits to shift (0 -> 1, > DR_MAX -> DR_MAX)
//   cmd_data              TDI payload, LSB shifted first
//   rsp_valid             one-cycle pulse when a scan completes
//   rsp_data              captured TDO bits, held until the next response
//   busy                  inverse of cmd_ready
//   TMS, TDI              registered TAP controls
//   TDO                   TAP serial output, sampled on CLK
//
// Build option
//   JTAG_SCAN_MASTER_TLR_EN  prefix every IR scan with 5x TMS=1 and 1x TMS=0
//                            so the TAP passes through TEST_LOGIC_RESET.
//
// The state register mirrors the TAP's current state; TMS/TDI hold the values
// the TAP consumes at the coming edge.
module jtag_scan_master #(
  parameter int DR_MAX = 16,
  parameter int LEN_W  = 5
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_ir,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DR_MAX-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DR_MAX-1:0] rsp_data,
  output logic              busy,
  output logic              TMS,
  output logic              TDI,
  input  logic              TDO
);

  localparam int IDX_W = (DR_MAX > 1) ? $clog2(DR_MAX) : 1;

  typedef enum logic [2:0] {
    INIT, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE
  } state_t;

  state_t             state;
  logic [2:0]         init_cnt;
  logic               ir_q;
  logic [IDX_W-1:0]   len_m1;   // last shift index
  logic [IDX_W-1:0]   bit_cnt;
  logic [DR_MAX-1:0]  data_q;
  logic [DR_MAX-1:0]  cap;      // collects TDO; published at scan end
`ifdef JTAG_SCAN_MASTER_TLR_EN
  logic               pend;     // IR scan waiting behind the TLR prefix
`endif

  // Clamped length, stored as (n-1) so it fits the bit index.
  logic [IDX_W-1:0] len_m1_in;
  always_comb begin
    len_m1_in = '0;
    if (cmd_len == '0)
      len_m1_in = '0;
    else if (cmd_len > LEN_W'(DR_MAX))
      len_m1_in = IDX_W'(DR_MAX - 1);
    else
      len_m1_in = IDX_W'(cmd_len - 1'b1);
  end

  assign busy = ~cmd_ready;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= INIT;
      init_cnt  <= '0;
      TMS       <= 1'b1;
      TDI       <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      cap       <= '0;
      ir_q      <= 1'b0;
      len_m1    <= '0;
      bit_cnt   <= '0;
      data_q    <= '0;
`ifdef JTAG_SCAN_MASTER_TLR_EN
      pend      <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        // Five TMS=1 edges reach TEST_LOGIC_RESET from anywhere; the sixth
        // edge (TMS=0) lands in RUN_TEST_IDLE.
        INIT: begin
          if (init_cnt == 3'd5) begin
            init_cnt <= '0;
            state    <= IDLE;
`ifdef JTAG_SCAN_MASTER_TLR_EN
            if (pend) begin
              pend <= 1'b0;
              TMS  <= 1'b1;       // start the held IR scan
            end else begin
              TMS       <= 1'b0;
              cmd_ready <= 1'b1;
            end
`else
            TMS       <= 1'b0;
            cmd_ready <= 1'b1;
`endif
          end else begin
            init_cnt <= init_cnt + 3'd1;
            TMS      <= (init_cnt != 3'd4);
          end
        end

        // With cmd_ready low we sit in RUN_TEST_IDLE presenting TMS=1 for
        // the move to SELECT_DR.
        IDLE: begin
          TDI <= 1'b0;
          if (cmd_ready) begin
            if (cmd_valid) begin
              cmd_ready <= 1'b0;
              ir_q      <= cmd_ir;
              len_m1    <= len_m1_in;
              data_q    <= cmd_data;
              bit_cnt   <= '0;
              cap       <= '0;
              TMS       <= 1'b1;
`ifdef JTAG_SCAN_MASTER_TLR_EN
              if (cmd_ir) begin
                pend     <= 1'b1;
                init_cnt <= '0;
                state    <= INIT;
              end
`endif
            end else begin
              TMS <= 1'b0;
            end
          end else begin
            state <= SEL_DR;
            TMS   <= ir_q;
          end
        end

        SEL_DR: begin
          state <= ir_q ? SEL_IR : CAPTURE;
          TMS   <= 1'b0;
        end

        SEL_IR: begin
          state <= CAPTURE;
          TMS   <= 1'b0;
        end

        CAPTURE: begin
          state <= SHIFT;
          TDI   <= data_q[0];
          TMS   <= (len_m1 == '0);
        end

        // Each SHIFT edge consumes one TDI bit and the TAP presents the
        // matching TDO bit in the same cycle.
        SHIFT: begin
          cap[bit_cnt] <= TDO;
          if (bit_cnt == len_m1) begin
            state <= EXIT1;
            TMS   <= 1'b1;
            TDI   <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            TDI     <= data_q[bit_cnt + 1'b1];
            TMS     <= ((bit_cnt + 1'b1) == len_m1);
          end
        end

        EXIT1: begin
          state <= UPDATE;
          TMS   <= 1'b0;
        end

        UPDATE: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b1;
          rsp_data  <= cap;
          TMS       <= 1'b0;
        end

        default: begin
          state    <= INIT;
          init_cnt <= '0;
          TMS      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master: paired with a behavioural 16-state TAP and a
// scan-level reference model (chain = old register bits followed by TDI bits).
module tb_jtag_scan_master;
  localparam int DR_MAX = 16;
  localparam int LEN_W  = 5;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ir = 1'b0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic [DR_MAX-1:0] cmd_data = '0;
  logic              cmd_ready, rsp_valid, busy, TMS, TDI, TDO;
  logic [DR_MAX-1:0] rsp_data;

  int n_chk = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  jtag_scan_master #(.DR_MAX(DR_MAX), .LEN_W(LEN_W)) dut (
    .CLK(CLK), .RESET(RESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .TMS(TMS), .TDI(TDI), .TDO(TDO)
  );

  // ---------------- TAP model ----------------
  typedef enum logic [3:0] {
    T_TLR, T_RTI, T_SDR, T_CDR, T_SHDR, T_E1DR, T_PDR, T_E2DR, T_UDR,
    T_SIR, T_CIR, T_SHIR, T_E1IR, T_PIR, T_E2IR, T_UIR
  } tap_t;

  tap_t        tap_st = T_TLR;
  logic [3:0]  tap_ir = 4'h1;
  logic [4:0]  tap_rega = '0;
  logic [6:0]  tap_regb = '0;
  logic [15:0] tap_regc = '0;
  logic [15:0] tap_sr = '0;
  int          tap_w = 16;

  function automatic tap_t tap_next(tap_t s, logic tms);
    case (s)
      T_TLR:  return tms ? T_TLR  : T_RTI;
      T_RTI:  return tms ? T_SDR  : T_RTI;
      T_SDR:  return tms ? T_SIR  : T_CDR;
      T_CDR:  return tms ? T_E1DR : T_SHDR;
      T_SHDR: return tms ? T_E1DR : T_SHDR;
      T_E1DR: return tms ? T_UDR  : T_PDR;
      T_PDR:  return tms ? T_E2DR : T_PDR;
      T_E2DR: return tms ? T_UDR  : T_SHDR;
      T_UDR:  return tms ? T_SDR  : T_RTI;
      T_SIR:  return tms ? T_TLR  : T_CIR;
      T_CIR:  return tms ? T_E1IR : T_SHIR;
      T_SHIR: return tms ? T_E1IR : T_SHIR;
      T_E1IR: return tms ? T_UIR  : T_PIR;
      T_PIR:  return tms ? T_E2IR : T_PIR;
      T_E2IR: return tms ? T_UIR  : T_SHIR;
      default: return tms ? T_SDR : T_RTI;
    endcase
  endfunction

  assign TDO = tap_sr[0];

  always @(posedge CLK) begin
    if (RESET) begin
      tap_st <= T_TLR;
      tap_ir <= 4'h1;
    end else begin
      tap_st <= tap_next(tap_st, TMS);
      case (tap_st)
        T_TLR: tap_ir <= 4'h1;
        T_CIR: begin tap_sr <= {12'h0, tap_ir}; tap_w <= 4; end
        T_CDR: begin
          if (tap_ir == 4'h2)      begin tap_sr <= {11'h0, tap_rega}; tap_w <= 5; end
          else if (tap_ir == 4'hE) begin tap_sr <= {9'h0, tap_regb};  tap_w <= 7; end
          else                     begin tap_sr <= tap_regc;          tap_w <= 16; end
        end
        T_SHIR, T_SHDR: tap_sr <= (tap_sr >> 1) | (16'(TDI) << (tap_w - 1));
        T_UIR: tap_ir <= tap_sr[3:0];
        T_UDR: begin
          if (tap_ir == 4'h2)      tap_rega <= tap_sr[4:0];
          else if (tap_ir == 4'hE) tap_regb <= tap_sr[6:0];
          else                     tap_regc <= tap_sr;
        end
        default: ;
      endcase
    end
  end

  // ---------------- reference model ----------------
  logic [3:0]  m_ir = 4'h1;
  logic [4:0]  m_rega = '0;
  logic [6:0]  m_regb = '0;
  logic [15:0] m_regc = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scan of n bits through a chain of width w: the serial stream is the old
  // register (LSB first) followed by the TDI payload; TDO returns stream bits
  // [n-1:0] and the register ends up with stream bits [n+w-1:n].
  task automatic ref_scan(input logic ir, input int len, input logic [15:0] d,
                          output logic [15:0] rsp, output int n);
    logic [63:0] seq, old, nw;
    int w;
    n = (len == 0) ? 1 : ((len > DR_MAX) ? DR_MAX : len);
`ifdef JTAG_SCAN_MASTER_TLR_EN
    if (ir) m_ir = 4'h1;
`endif
    if (ir)                  begin w = 4;  old = 64'(m_ir);   end
    else if (m_ir == 4'h2)   begin w = 5;  old = 64'(m_rega); end
    else if (m_ir == 4'hE)   begin w = 7;  old = 64'(m_regb); end
    else                     begin w = 16; old = 64'(m_regc); end
    seq = (64'(d) << w) | old;
    rsp = 16'(seq & ((64'd1 << n) - 64'd1));
    nw  = (seq >> n) & ((64'd1 << w) - 64'd1);
    if (ir)                m_ir   = 4'(nw);
    else if (m_ir == 4'h2) m_rega = 5'(nw);
    else if (m_ir == 4'hE) m_regb = 7'(nw);
    else                   m_regc = 16'(nw);
  endtask

  // Called at the negedge of the first cycle after the last reset edge.
  task automatic init_check();
    logic [6:0] tms_v, rdy_v;
    logic       rv;
    tms_v = '0; rdy_v = '0; rv = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      tms_v[k] = TMS;
      rdy_v[k] = cmd_ready;
      rv |= rsp_valid;
      if (k < 6) @(negedge CLK);
    end
    check("init_tms",   64'(tms_v[5:0]), 64'h1F);
    check("init_ready", 64'(rdy_v), 64'h40);
    check("init_no_rsp", 64'(rv), 64'd0);
    check("init_tap_rti", 64'(tap_st == T_RTI), 64'd1);
  endtask

  // Called on a negedge; returns at the negedge of the rsp_valid cycle.
  task automatic do_scan(input logic ir, input int len, input logic [15:0] d,
                         input bit junk, output int waited);
    logic [63:0] exp_tms, got_tms;
    logic [15:0] exp_rsp;
    int n, L, k;
    bit busy_ok, done;
    waited = 0;
    while (cmd_ready !== 1'b1 && waited < 100) begin @(negedge CLK); waited++; end
    check("ready_wait", 64'(cmd_ready), 64'd1);
    if (cmd_ready !== 1'b1) return;
    cmd_valid = 1'b1; cmd_ir = ir; cmd_len = LEN_W'(len); cmd_data = d;
    ref_scan(ir, len, d, exp_rsp, n);
    exp_tms = '0; L = 0;
`ifdef JTAG_SCAN_MASTER_TLR_EN
    if (ir) begin
      for (int i = 0; i < 5; i++) begin exp_tms[L] = 1'b1; L++; end
      L++;
    end
`endif
    exp_tms[L] = 1'b1; L++;
    if (ir) begin exp_tms[L] = 1'b1; L++; end
    L += 2;
    for (int i = 0; i < n; i++) begin exp_tms[L] = (i == n - 1); L++; end
    exp_tms[L] = 1'b1; L++;
    L++;
    got_tms = '0; busy_ok = 1'b1; done = 1'b0; k = 0;
    while (!done && k < 60) begin
      @(negedge CLK); k++;
      if (rsp_valid === 1'b1) done = 1'b1;
      else begin
        got_tms[k-1] = TMS;
        busy_ok &= (busy === 1'b1 && cmd_ready === 1'b0);
        if (junk) begin
          cmd_valid = 1'b1; cmd_ir = 1'($urandom);
          cmd_len = LEN_W'($urandom); cmd_data = DR_MAX'($urandom);
        end else cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    check("rsp_seen", 64'(done), 64'd1);
    check("latency",  64'(k - 1), 64'(L));
    check("tms_seq",  got_tms, exp_tms);
    check("rsp_data", 64'(rsp_data), 64'(exp_rsp));
    check("busy_during_scan", 64'(busy_ok), 64'd1);
    check("tap_rti_end", 64'(tap_st == T_RTI), 64'd1);
    check("tap_regs", {32'h0, tap_ir, tap_rega, tap_regb, tap_regc},
                      {32'h0, m_ir, m_rega, m_regb, m_regc});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    repeat (2) @(negedge CLK);
    check("rst_tms",   64'(TMS), 64'd1);
    check("rst_tdi",   64'(TDI), 64'd0);
    check("rst_ready", 64'(cmd_ready), 64'd0);
    check("rst_busy",  64'(busy), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data",  64'(rsp_data), 64'd0);
    RESET = 1'b0;
    init_check();

    // IR=2 returns the IDCODE-style reset IR, then regA write/readback.
    do_scan(1'b1, 4, 16'h0002, 1'b0, w);
    check("ir_prev", 64'(rsp_data[3:0]), 64'h1);
    do_scan(1'b0, 5, 16'h0015, 1'b0, w);
    do_scan(1'b0, 5, 16'h000A, 1'b0, w);
    check("rega_readback", 64'(rsp_data), 64'h15);

    // Back-to-back: DR accepted on the rsp_valid cycle of the IR scan.
    do_scan(1'b1, 4, 16'h000E, 1'b0, w);
    do_scan(1'b0, 7, 16'h005A, 1'b0, w);
    check("b2b_no_gap", 64'(w), 64'd0);
    check("b2b_regb", 64'(tap_regb), 64'h5A);
    check("b2b_upper_zero", 64'(rsp_data[15:7]), 64'd0);

    // Boundaries on the 16-bit register (IR=1).
    do_scan(1'b1, 4, 16'h0001, 1'b0, w);
    do_scan(1'b0, 0, 16'hFFFF, 1'b0, w);
    do_scan(1'b0, 20, 16'hC3A5, 1'b0, w);
    do_scan(1'b0, 16, 16'h1234, 1'b0, w);
    check("clamp_readback", 64'(rsp_data), 64'hC3A5);

    // Commands offered while busy are dropped.
    do_scan(1'b0, 9, 16'h01B7, 1'b1, w);
    do_scan(1'b1, 4, 16'h0002, 1'b1, w);

    for (int i = 0; i < 40; i++) begin
      do_scan(($urandom_range(0, 3) == 0), $urandom_range(0, 20),
              16'($urandom), 1'($urandom), w);
    end

    // Reset while the DR scan is presenting shift bit 3.
    do_scan(1'b1, 4, 16'h0001, 1'b0, w);
    cmd_valid = 1'b1; cmd_ir = 1'b0; cmd_len = LEN_W'(10); cmd_data = 16'h0208;
    @(negedge CLK);
    cmd_valid = 1'b0;
    repeat (6) @(negedge CLK);
    check("mid_tap_shift", 64'(tap_st == T_SHDR), 64'd1);
    check("mid_tdi_bit3", 64'(TDI), 64'd1);
    RESET = 1'b1;
    @(negedge CLK);
    check("mid_rst_tms", 64'(TMS), 64'd1);
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_rsp_data", 64'(rsp_data), 64'd0);
    check("mid_rst_ready", 64'(cmd_ready), 64'd0);
    RESET = 1'b0;
    m_ir = 4'h1;
    init_check();
    do_scan(1'b0, 16, 16'hBEEF, 1'b0, w);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
